// File: rtl/census_transform_3x3_if.sv
// Pixel-in / census-out stream bundle for the 3x3 census transform.
interface census_if #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
);
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic [PIX_WIDTH-1:0] pix_in;
    logic                 valid_in;
    logic                 sof_in;
    logic [7:0]           census_out;
    logic [XW-1:0]        out_x;
    logic [YW-1:0]        out_y;
    logic                 valid_out;
    logic                 frame_done;

    modport master (
        output pix_in, valid_in, sof_in,
        input  census_out, out_x, out_y, valid_out, frame_done
    );

    modport slave (
        input  pix_in, valid_in, sof_in,
        output census_out, out_x, out_y, valid_out, frame_done
    );
endinterface

// File: rtl/census_transform_3x3.sv
// Streaming 3x3 census transform: two line buffers feed a 3x3 shift window,
// each interior window centre is encoded as an 8-bit neighbour<centre vector.
module census_transform_3x3 #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input logic     clk,
    input logic     rst,
    census_if.slave bus
);
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam int unsigned CW = 8;

    logic [XW-1:0]        col;
    logic [YW-1:0]        row;
    logic [XW-1:0]        cur_col_c;
    logic [YW-1:0]        cur_row_c;
    logic [PIX_WIDTH-1:0] line0 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] tap0_c;
    logic [PIX_WIDTH-1:0] tap1_c;
    logic [2:0][2:0][PIX_WIDTH-1:0] win;
    logic                 emit_q;
    logic                 last_q;
    logic [XW-1:0]        cx_q;
    logic [YW-1:0]        cy_q;
    logic [CW-1:0]        census_c;

    // Position of the incoming pixel (sof forces 0,0) and line-buffer taps at its column
    always_comb begin
        cur_col_c = bus.sof_in ? '0 : col;
        cur_row_c = bus.sof_in ? '0 : row;
        tap0_c    = line0[cur_col_c];
        tap1_c    = line1[cur_col_c];
    end

    // Raster counters, advanced only by accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.valid_in) begin
            if (cur_col_c == XW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row_c == YW'(IMG_HEIGHT - 1)) ? '0 : cur_row_c + YW'(1);
            end else begin
                col <= cur_col_c + XW'(1);
                row <= cur_row_c;
            end
        end
    end

    // Line buffers: older line takes the newer line, newer line takes the pixel (not reset)
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            line0[cur_col_c] <= tap1_c;
            line1[cur_col_c] <= bus.pix_in;
        end
    end

    // Window shift plus centre coordinates; emission only for r>=2, c>=2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win    <= '0;
            emit_q <= 1'b0;
            last_q <= 1'b0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else begin
            emit_q <= bus.valid_in && (cur_row_c >= YW'(2)) && (cur_col_c >= XW'(2));
            if (bus.valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= tap0_c;
                win[1][2] <= tap1_c;
                win[2][2] <= bus.pix_in;
                cx_q      <= cur_col_c - XW'(1);
                cy_q      <= cur_row_c - YW'(1);
                last_q    <= (cur_col_c == XW'(IMG_WIDTH - 1)) &&
                             (cur_row_c == YW'(IMG_HEIGHT - 1));
            end
        end
    end

    // Neighbour-vs-centre compare, raster order of neighbours gives bit order
    always_comb begin
        census_c    = '0;
        census_c[0] = win[0][0] < win[1][1];
        census_c[1] = win[0][1] < win[1][1];
        census_c[2] = win[0][2] < win[1][1];
        census_c[3] = win[1][0] < win[1][1];
        census_c[4] = win[1][2] < win[1][1];
        census_c[5] = win[2][0] < win[1][1];
        census_c[6] = win[2][1] < win[1][1];
        census_c[7] = win[2][2] < win[1][1];
    end

    // Registered outputs; code and coordinates hold while no output is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.census_out <= '0;
            bus.out_x      <= '0;
            bus.out_y      <= '0;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= emit_q;
            bus.frame_done <= emit_q & last_q;
            if (emit_q) begin
                bus.census_out <= census_c;
                bus.out_x      <= cx_q;
                bus.out_y      <= cy_q;
            end
        end
    end
endmodule

// File: tb/tb_census_transform_3x3.sv
// Self-checking bench for census_transform_3x3 on an 8x6 image.
module tb_census_transform_3x3;
    localparam int unsigned W = 8;
    localparam int unsigned H = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    census_if #(.PIX_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    census_transform_3x3 #(.PIX_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int y;
        int code;
        bit done;
        int cyc;
    } exp_t;

    typedef struct {
        string name;
        int    sr;
        int    sc;
        int    sval;
        int    cr;
        int    cc;
        int    expc;
    } vec_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         mr = 0;
    int         mc = 0;
    logic [7:0] img [H][W];
    int         cap [H][W];
    int         mon_outs, mon_dones, first_x, first_y;
    vec_t       vecs [15];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference census straight from the stored image: neighbours in raster order
    function automatic int ref_census(int y, int x);
        int b = 0;
        int code = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dy == 0 && dx == 0)) begin
                    if (img[y+dy][x+dx] < img[y][x]) code = code | (1 << b);
                    b++;
                end
        return code;
    endfunction

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    task automatic drive(input int pix, input bit sof);
        @(negedge clk);
        bus.pix_in   = 8'(pix);
        bus.valid_in = 1'b1;
        bus.sof_in   = sof;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = 8'(pix);
        if (mr >= 2 && mc >= 2)
            sbq.push_back('{mc - 1, mr - 1, ref_census(mr - 1, mc - 1),
                            (mr == H - 1 && mc == W - 1), cyc + 2});
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            bus.sof_in   = 1'b0;
            bus.pix_in   = 8'($urandom_range(255));
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 20) begin
            idle(1);
            t++;
        end
        idle(2);
        check("drain_pending", sbq.size(), 0);
    endtask

    task automatic clear_mon();
        mon_outs  = 0;
        mon_dones = 0;
        first_x   = -1;
        first_y   = -1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) cap[y][x] = -1;
    endtask

    task automatic run_table_frame(input int sr, input int sc, input int sval);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive((r == sr && c == sc) ? sval : 100, (r == 0 && c == 0));
    endtask

    task automatic run_random_frame(input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps) while ($urandom_range(1) == 0) idle(1);
            drive($urandom_range(255), i == 0);
        end
    endtask

    task automatic frame_counts(input string tag);
        check({tag, "_outputs"}, mon_outs, 24);
        check({tag, "_frame_done"}, mon_dones, 1);
        check({tag, "_first_x"}, first_x, 1);
        check({tag, "_first_y"}, first_y, 1);
    endtask

    // Output monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out) begin
                exp_t e;
                mon_outs++;
                if (mon_outs == 1) begin
                    first_x = int'(bus.out_x);
                    first_y = int'(bus.out_y);
                end
                if (int'(bus.out_y) < H && int'(bus.out_x) < W)
                    cap[bus.out_y][bus.out_x] = int'(bus.census_out);
                if (bus.frame_done) mon_dones++;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_output: got unexpected x=%0d y=%0d code=%02h, required no output",
                             bus.out_x, bus.out_y, bus.census_out);
                end else begin
                    e = sbq.pop_front();
                    if (int'(bus.out_x) != e.x || int'(bus.out_y) != e.y ||
                        int'(bus.census_out) != e.code || bus.frame_done != e.done || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL sb_output: got x=%0d y=%0d code=%02h done=%0d cyc=%0d, required x=%0d y=%0d code=%02h done=%0d cyc=%0d",
                                 bus.out_x, bus.out_y, bus.census_out, bus.frame_done, cyc,
                                 e.x, e.y, e.code, e.done, e.cyc);
                    end
                end
            end else if (bus.frame_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_done_alone: got frame_done=1 with valid_out=0, required 0");
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"flat_c11",   0, 0, 100, 1, 1, 8'h00};
        vecs[1]  = '{"flat_c46",   0, 0, 100, 4, 6, 8'h00};
        vecs[2]  = '{"bright_c23", 2, 3, 200, 2, 3, 8'hFF};
        vecs[3]  = '{"bright_c12", 2, 3, 200, 1, 2, 8'h00};
        vecs[4]  = '{"bright_c13", 2, 3, 200, 1, 3, 8'h00};
        vecs[5]  = '{"bright_c14", 2, 3, 200, 1, 4, 8'h00};
        vecs[6]  = '{"bright_c22", 2, 3, 200, 2, 2, 8'h00};
        vecs[7]  = '{"bright_c24", 2, 3, 200, 2, 4, 8'h00};
        vecs[8]  = '{"bright_c33", 2, 3, 200, 3, 3, 8'h00};
        vecs[9]  = '{"dark_c11",   2, 2, 50,  1, 1, 8'h80};
        vecs[10] = '{"dark_c12",   2, 2, 50,  1, 2, 8'h40};
        vecs[11] = '{"dark_c13",   2, 2, 50,  1, 3, 8'h20};
        vecs[12] = '{"dark_c21",   2, 2, 50,  2, 1, 8'h10};
        vecs[13] = '{"dark_c33",   2, 2, 50,  3, 3, 8'h01};
        vecs[14] = '{"dark_c23",   2, 2, 50,  2, 3, 8'h08};

        bus.pix_in   = '0;
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_census", int'(bus.census_out), 0);
        check("rst_out_x", int'(bus.out_x), 0);
        check("rst_out_y", int'(bus.out_y), 0);
        check("rst_valid", int'(bus.valid_out), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed frames: flat, one bright pixel, one dark pixel
        foreach (vecs[i]) begin
            clear_mon();
            run_table_frame(vecs[i].sr, vecs[i].sc, vecs[i].sval);
            drain();
            check(vecs[i].name, cap[vecs[i].cr][vecs[i].cc], vecs[i].expc);
            if (i == 0 || i == 2 || i == 9) frame_counts(vecs[i].name);
        end

        // Random pixels with random input gaps
        for (int f = 0; f < 2; f++) begin
            clear_mon();
            run_random_frame(1'b1);
            drain();
            frame_counts("random");
        end

        // Mid-frame sof at (3,5) aborts frame 1
        clear_mon();
        for (int i = 0; i < 3 * W + 5; i++) drive($urandom_range(255), i == 0);
        drain();
        check("abort_no_done", mon_dones, 0);
        clear_mon();
        run_random_frame(1'b0);
        drain();
        frame_counts("after_sof");

        // Reset pulse right after pixel (4,4)
        clear_mon();
        for (int i = 0; i <= 4 * W + 4; i++) drive($urandom_range(255), i == 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        sbq.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        check("rst_mid_valid", int'(bus.valid_out), 0);
        check("rst_mid_done", int'(bus.frame_done), 0);
        check("rst_mid_census", int'(bus.census_out), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2);
        clear_mon();
        run_random_frame(1'b1);
        drain();
        frame_counts("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
